// File: rtl/csr_counters_pkg.sv
// Shared CSR constants for the counter/timer block: addresses, mcountinhibit bit indices, default widths.
package csr_counters_pkg;

  localparam int CNT_W_DEF = 64;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] ADDR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] ADDR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] ADDR_HPMCOUNTER3H  = 12'hC83;
  localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;

  localparam int INH_CY   = 0;
  localparam int INH_IR   = 2;
  localparam int INH_HPM3 = 3;

endpackage

// File: rtl/csr_counter_reg.sv
// Single CNT_W-bit counter with split XLEN-wide low/high writes.
// A write to either half suppresses the increment for that cycle, so no carry reaches the other half.
module csr_counter_reg
  import csr_counters_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wr_data,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[XLEN-1:0] <= wr_data;
    end else if (wr_hi) begin
      value[CNT_W-1:XLEN] <= wr_data[CNT_W-XLEN-1:0];
    end else if (inc) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_counters.sv
// Machine counter/timer store (mcycle, minstret, mcountinhibit + user aliases); reads are combinational.
// Optional mhpmcounter3/mhpmevent3 are built when CSR_COUNTERS_HPM_EN is defined.
module csr_counters
  import csr_counters_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int EVENT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               retire,
  input  logic               debug,
  input  logic               stopcount,
  input  logic [11:0]        rd_addr,
  output logic [XLEN-1:0]    rd_data,
  output logic               rd_hit,
  input  logic               wr_en,
  input  logic [11:0]        wr_addr,
  input  logic [XLEN-1:0]    wr_data,
  input  logic [EVENT_W-1:0] events
);

  logic             freeze;
  logic             inh_cy;
  logic             inh_ir;
  logic             wr_inh;
  logic [CNT_W-1:0] cy_val;
  logic [CNT_W-1:0] ir_val;

  assign freeze = debug && stopcount;
  assign wr_inh = wr_en && (wr_addr == ADDR_MCOUNTINHIBIT);

  // Inhibit bits are registered, so a write only affects the following cycle's increments.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else if (wr_inh) begin
      inh_cy <= wr_data[INH_CY];
      inh_ir <= wr_data[INH_IR];
    end
  end

  csr_counter_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_cycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (!inh_cy && !freeze),
    .wr_lo   (wr_en && (wr_addr == ADDR_MCYCLE)),
    .wr_hi   (wr_en && (wr_addr == ADDR_MCYCLEH)),
    .wr_data (wr_data),
    .value   (cy_val)
  );

  csr_counter_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_instret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire && !inh_ir && !freeze),
    .wr_lo   (wr_en && (wr_addr == ADDR_MINSTRET)),
    .wr_hi   (wr_en && (wr_addr == ADDR_MINSTRETH)),
    .wr_data (wr_data),
    .value   (ir_val)
  );

`ifdef CSR_COUNTERS_HPM_EN
  localparam int EV_W = $clog2(EVENT_W) + 1;

  logic             inh_hpm;
  logic [EV_W-1:0]  hpm_sel;
  logic             hpm_evt;
  logic [CNT_W-1:0] hpm_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_hpm <= 1'b0;
      hpm_sel <= '0;
    end else begin
      if (wr_inh) inh_hpm <= wr_data[INH_HPM3];
      if (wr_en && (wr_addr == ADDR_MHPMEVENT3)) hpm_sel <= wr_data[EV_W-1:0];
    end
  end

  // Selector 0 and values above EVENT_W select nothing.
  always_comb begin
    hpm_evt = 1'b0;
    for (int k = 1; k <= EVENT_W; k++) begin
      if (hpm_sel == EV_W'(k)) hpm_evt = events[k-1];
    end
  end

  csr_counter_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_hpm3 (
    .clk     (clk),
    .rst     (rst),
    .inc     (hpm_evt && !inh_hpm && !freeze),
    .wr_lo   (wr_en && (wr_addr == ADDR_MHPMCOUNTER3)),
    .wr_hi   (wr_en && (wr_addr == ADDR_MHPMCOUNTER3H)),
    .wr_data (wr_data),
    .value   (hpm_val)
  );
`else
  logic events_unused;
  assign events_unused = ^events;
`endif

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    case (rd_addr)
      ADDR_MCYCLE, ADDR_CYCLE: begin
        rd_hit  = 1'b1;
        rd_data = cy_val[XLEN-1:0];
      end
      ADDR_MCYCLEH, ADDR_CYCLEH: begin
        rd_hit  = 1'b1;
        rd_data = XLEN'(cy_val[CNT_W-1:XLEN]);
      end
      ADDR_MINSTRET, ADDR_INSTRET: begin
        rd_hit  = 1'b1;
        rd_data = ir_val[XLEN-1:0];
      end
      ADDR_MINSTRETH, ADDR_INSTRETH: begin
        rd_hit  = 1'b1;
        rd_data = XLEN'(ir_val[CNT_W-1:XLEN]);
      end
      ADDR_MCOUNTINHIBIT: begin
        rd_hit          = 1'b1;
        rd_data[INH_CY] = inh_cy;
        rd_data[INH_IR] = inh_ir;
`ifdef CSR_COUNTERS_HPM_EN
        rd_data[INH_HPM3] = inh_hpm;
`endif
      end
`ifdef CSR_COUNTERS_HPM_EN
      ADDR_MHPMCOUNTER3, ADDR_HPMCOUNTER3: begin
        rd_hit  = 1'b1;
        rd_data = hpm_val[XLEN-1:0];
      end
      ADDR_MHPMCOUNTER3H, ADDR_HPMCOUNTER3H: begin
        rd_hit  = 1'b1;
        rd_data = XLEN'(hpm_val[CNT_W-1:XLEN]);
      end
      ADDR_MHPMEVENT3: begin
        rd_hit  = 1'b1;
        rd_data = XLEN'(hpm_sel);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_counters.sv
// Directed bench for csr_counters: reads push expected values into a scoreboard, a monitor pops and compares.
module tb_csr_counters;
  import csr_counters_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic        debug = 1'b0;
  logic        stopcount = 1'b0;
  logic [11:0] rd_addr = 12'h000;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = 12'h000;
  logic [31:0] wr_data = 32'h0;
  logic [7:0]  events = 8'h00;

  always #5 clk = ~clk;

  csr_counters #(.XLEN(32), .CNT_W(64), .EVENT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .retire    (retire),
    .debug     (debug),
    .stopcount (stopcount),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .events    (events)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  always begin
    @(sample_ev);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: monitor sampled with no expected entry");
    end else begin
      mon_e = sb.pop_front();
      checks++;
      if (rd_data !== mon_e.data || rd_hit !== mon_e.hit) begin
        errors++;
        $display("FAIL %s: got data=%h hit=%b, expected data=%h hit=%b",
                 mon_e.name, rd_data, rd_hit, mon_e.data, mon_e.hit);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h, input string nm);
    rd_addr = a;
    #1;
    sb.push_back('{name: nm, data: d, hit: h});
    -> sample_ev;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    rd(ADDR_MCYCLE,        32'h0, 1'b1, "rst_mcycle");
    rd(ADDR_MCYCLEH,       32'h0, 1'b1, "rst_mcycleh");
    rd(ADDR_MCOUNTINHIBIT, 32'h0, 1'b1, "rst_inhibit");
    rd(12'h123,            32'h0, 1'b0, "unmapped");

    repeat (10) tick();
    rd(ADDR_MCYCLE,   32'h0000000A, 1'b1, "idle10_mcycle");
    rd(ADDR_CYCLE,    32'h0000000A, 1'b1, "idle10_cycle_alias");
    rd(ADDR_MINSTRET, 32'h0,        1'b1, "idle10_minstret");

    // Low write then high write: neither cycle increments.
    wr(ADDR_MCYCLE,  32'hFFFF_FFFF);
    wr(ADDR_MCYCLEH, 32'h0);
    rd(ADDR_CYCLE,  32'hFFFF_FFFF, 1'b1, "wr_wins_lo");
    rd(ADDR_CYCLEH, 32'h0,         1'b1, "wr_wins_hi");
    tick();
    rd(ADDR_MCYCLEH, 32'h1, 1'b1, "carry_hi");
    rd(ADDR_MCYCLE,  32'h0, 1'b1, "carry_lo");

    retire = 1'b1;
    wr(ADDR_MCOUNTINHIBIT, 32'h5);
    repeat (20) tick();
    rd(ADDR_MCYCLE,   32'h1, 1'b1, "inh_mcycle");
    rd(ADDR_MCYCLEH,  32'h1, 1'b1, "inh_mcycleh");
    rd(ADDR_MINSTRET, 32'h1, 1'b1, "inh_minstret");
    tick();
    rd(ADDR_MCOUNTINHIBIT, 32'h5, 1'b1, "inh_read5");
    wr(ADDR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
`ifdef CSR_COUNTERS_HPM_EN
    rd(ADDR_MCOUNTINHIBIT, 32'hD, 1'b1, "inh_mask");
`else
    rd(ADDR_MCOUNTINHIBIT, 32'h5, 1'b1, "inh_mask");
`endif

    wr(ADDR_MCOUNTINHIBIT, 32'h0);
    wr(ADDR_MINSTRET, 32'h100);
    retire = 1'b0;
    rd(ADDR_MINSTRET,  32'h100, 1'b1, "ir_wr_wins");
    rd(ADDR_MINSTRETH, 32'h0,   1'b1, "ir_wr_wins_hi");
    rd(ADDR_MCYCLE,    32'h2,   1'b1, "cy_after_uninhibit");

    debug = 1'b1;
    stopcount = 1'b1;
    retire = 1'b1;
    repeat (5) tick();
    rd(ADDR_MCYCLE,   32'h2,   1'b1, "freeze_mcycle");
    rd(ADDR_MINSTRET, 32'h100, 1'b1, "freeze_minstret");
    stopcount = 1'b0;
    repeat (5) tick();
    rd(ADDR_MCYCLE,   32'h7,   1'b1, "debug_run_mcycle");
    rd(ADDR_MINSTRET, 32'h105, 1'b1, "debug_run_minstret");
    rd(ADDR_MCYCLEH,  32'h1,   1'b1, "debug_run_mcycleh");
    retire = 1'b0;
    debug = 1'b0;

    wr(ADDR_CYCLE, 32'h55);
    rd(ADDR_MCYCLE, 32'h8, 1'b1, "ro_alias_wr_ignored");

    rst = 1'b1;
    retire = 1'b1;
    wr(ADDR_MINSTRET, 32'h77);
    rst = 1'b0;
    retire = 1'b0;
    rd(ADDR_MCYCLE,   32'h0, 1'b1, "rst_wins_mcycle");
    rd(ADDR_MINSTRET, 32'h0, 1'b1, "rst_wins_minstret");
    rd(ADDR_MCYCLEH,  32'h0, 1'b1, "rst_wins_mcycleh");

`ifdef CSR_COUNTERS_HPM_EN
    wr(ADDR_MHPMEVENT3, 32'h2);
    for (int i = 0; i < 7; i++) begin
      events = 8'h02;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      events = 8'h01;
      tick();
    end
    events = 8'h00;
    rd(ADDR_MHPMCOUNTER3, 32'h7, 1'b1, "hpm_count");
    rd(ADDR_HPMCOUNTER3,  32'h7, 1'b1, "hpm_alias");
    rd(ADDR_MHPMEVENT3,   32'h2, 1'b1, "hpm_event");
    wr(ADDR_HPMCOUNTER3, 32'h0);
    rd(ADDR_MHPMCOUNTER3, 32'h7, 1'b1, "hpm_ro_wr_ignored");
    events = 8'h02;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    events = 8'h00;
    rd(ADDR_MHPMCOUNTER3, 32'h0, 1'b1, "hpm_rst_count");
    rd(ADDR_MHPMEVENT3,   32'h0, 1'b1, "hpm_rst_event");
    rd(ADDR_MCYCLE,       32'h0, 1'b1, "hpm_rst_mcycle");
`else
    rd(ADDR_MHPMCOUNTER3, 32'h0, 1'b0, "no_hpm_counter");
    rd(ADDR_MHPMEVENT3,   32'h0, 1'b0, "no_hpm_event");
`endif

    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
